instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning program-address width (equal to the program counter's WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning instruction word width.
REQ-003 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pc_in  in  ADDR_WIDTH  current program-counter value.
REQ-006 SHALL have port pc_ce  out  1  one-cycle count-enable pulse to the program counter.
REQ-007 SHALL have port pc_load  out  1  one-cycle load pulse to the program counter.
REQ-008 SHALL have port pc_preset  out  ADDR_WIDTH  value loaded into the program counter.
REQ-009 SHALL have port mem_req  out  1  memory read request.
REQ-010 SHALL have port mem_addr  out  ADDR_WIDTH  memory read address.
REQ-011 SHALL have port mem_ack  in  1  read data valid; completes the request.
REQ-012 SHALL have port mem_rdata  in  DATA_WIDTH  read data.
REQ-013 SHALL have port ir_out  out  DATA_WIDTH  fetched instruction.
REQ-014 SHALL have port ir_valid  out  1  ir_out valid to the decoder.
REQ-015 SHALL have port ir_ready  in  1  decoder accepts ir_out.
REQ-016 SHALL have port jump_req  in  1  redirect request, single-cycle.
REQ-017 SHALL have port jump_addr  in  ADDR_WIDTH  redirect target.
REQ-018 SHALL have port fetch_fault  out  1  sticky memory-timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, HOLD, JUMP, FAULT; all outputs registered.
REQ-020 SHALL move IDLE->REQ unconditionally on the first edge after reset release.
REQ-021 SHALL, in REQ, drive mem_req=1 and mem_addr=pc_in.
REQ-022 SHALL, in REQ with mem_ack=1 at the edge, latch mem_rdata into ir_out, set ir_valid=1, pulse pc_ce for exactly one cycle, and enter HOLD.
REQ-023 SHALL hold ir_out and ir_valid stable in HOLD until ir_valid && ir_ready at an edge, then clear ir_valid and enter REQ; minimum ack-to-next-mem_req spacing is 2 cycles.
REQ-024 SHALL give jump_req priority in REQ and HOLD: enter JUMP; clear ir_valid; discard any same-cycle mem_ack data; suppress pc_ce.
REQ-025 SHALL, in HOLD with simultaneous ir_ready and jump_req, complete the transfer and take the jump.
REQ-026 SHALL, in JUMP, drive pc_load=1 and pc_preset=jump_addr for exactly one cycle, then enter REQ.
REQ-027 SHALL never assert pc_ce and pc_load in the same cycle.
REQ-028 SHALL ignore jump_req in IDLE and FAULT.
REQ-029 SHALL rely on pc_in wrapping naturally from all-ones to zero; no wrap detection.

Reset
REQ-030 SHALL, on reset, force IDLE with all outputs zero: pc_ce, pc_load, pc_preset, mem_req, mem_addr, ir_out, ir_valid, fetch_fault.
REQ-031 SHALL, on reset mid-request, drop mem_req immediately, asynchronously, and ignore a late mem_ack.

Configuration
REQ-032 SHALL, with INSTR_FETCH_TIMEOUT_EN defined, count consecutive REQ cycles without mem_ack; reaching 15 SHALL set fetch_fault, drop mem_req, and enter FAULT, left only by reset.
REQ-033 SHALL, without INSTR_FETCH_TIMEOUT_EN, wait indefinitely in REQ, tie fetch_fault to 0, and never reach FAULT.

Structure
REQ-034 SHALL place the FSM state enum, the timeout limit constant (15), and the timer width (4) in shared package eclair_fetch_pkg.
REQ-035 SHALL implement the timeout as sub-module fetch_timeout_timer (clear, enable, expired), instantiated only under INSTR_FETCH_TIMEOUT_EN.

Verification
REQ-036 SHALL cover: reset release, pc_in=0x10, mem_ack after 2 cycles with rdata=0xA5 -> ir_out=0xA5, ir_valid=1, one pc_ce pulse, mem_addr=0x10.
REQ-037 SHALL cover: ir_ready held low 5 cycles in HOLD -> ir_out stable, no new mem_req; ready=1 -> next mem_req with mem_addr=0x11.
REQ-038 SHALL cover: jump_req with jump_addr=0x40 in the same cycle as mem_ack -> data discarded, pc_load one cycle with pc_preset=0x40, next mem_addr=0x40, no pc_ce.
REQ-039 SHALL cover: pc_in=0xFF fetch -> pc_ce pulse, next mem_addr=0x00.
REQ-040 SHALL cover: with INSTR_FETCH_TIMEOUT_EN and mem_ack never asserted -> fetch_fault=1 after 15 REQ cycles, mem_req=0, stays until reset.
REQ-041 SHALL cover: reset asserted mid-REQ -> mem_req=0 with no clock edge, all outputs zero.

Source files
------------

// File: rtl/eclair_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package eclair_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        JUMP,
        FAULT
    } fetch_state_t;

    localparam int TIMEOUT_LIMIT = 15;
    localparam int TIMER_WIDTH   = 4;

endpackage

// File: rtl/fetch_timeout_timer.sv
// Counts consecutive enabled cycles; expired is high on the cycle that reaches TIMEOUT_LIMIT.
module fetch_timeout_timer
    import eclair_fetch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_WIDTH-1:0] LAST = TIMER_WIDTH'(TIMEOUT_LIMIT - 1);

    logic [TIMER_WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    // Combinational so the FSM can leave REQ at the end of the limiting cycle itself.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM with registered outputs and jump redirect.
// Optional memory timeout enabled by defining INSTR_FETCH_TIMEOUT_EN.
module instr_fetch
    import eclair_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  pc_ce,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_preset,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ir_out,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    input  logic                  jump_req,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  fetch_fault
);

    fetch_state_t state, next_state;

    logic                  nxt_pc_ce;
    logic                  nxt_pc_load;
    logic [ADDR_WIDTH-1:0] nxt_pc_preset;
    logic                  nxt_mem_req;
    logic [ADDR_WIDTH-1:0] nxt_mem_addr;
    logic [DATA_WIDTH-1:0] nxt_ir_out;
    logic                  nxt_ir_valid;
    logic                  ack_taken;
    logic                  timeout_expired;

    // An ack only counts once the registered request is actually on the bus.
    assign ack_taken = mem_req && mem_ack;

`ifdef INSTR_FETCH_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;
    logic fault_q;

    assign timer_clear  = (state != REQ);
    assign timer_enable = (state == REQ) && !jump_req && !ack_taken;

    fetch_timeout_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timeout_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (next_state == FAULT);
        end
    end

    assign fetch_fault = fault_q;
`else
    assign timeout_expired = 1'b0;
    assign fetch_fault     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc_ce     <= 1'b0;
            pc_load   <= 1'b0;
            pc_preset <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            ir_out    <= '0;
            ir_valid  <= 1'b0;
        end else begin
            state     <= next_state;
            pc_ce     <= nxt_pc_ce;
            pc_load   <= nxt_pc_load;
            pc_preset <= nxt_pc_preset;
            mem_req   <= nxt_mem_req;
            mem_addr  <= nxt_mem_addr;
            ir_out    <= nxt_ir_out;
            ir_valid  <= nxt_ir_valid;
        end
    end

    // Next-state and next-output values; the request is raised one cycle after
    // entering REQ so pc_in has already absorbed the previous pc_ce pulse.
    always_comb begin
        next_state    = state;
        nxt_pc_ce     = 1'b0;
        nxt_pc_load   = 1'b0;
        nxt_pc_preset = pc_preset;
        nxt_mem_req   = 1'b0;
        nxt_mem_addr  = mem_addr;
        nxt_ir_out    = ir_out;
        nxt_ir_valid  = ir_valid;

        case (state)
            IDLE: begin
                next_state = REQ;
            end
            REQ: begin
                if (jump_req) begin
                    next_state    = JUMP;
                    nxt_pc_load   = 1'b1;
                    nxt_pc_preset = jump_addr;
                    nxt_ir_valid  = 1'b0;
                end else if (ack_taken) begin
                    next_state   = HOLD;
                    nxt_ir_out   = mem_rdata;
                    nxt_ir_valid = 1'b1;
                    nxt_pc_ce    = 1'b1;
                end else if (timeout_expired) begin
                    next_state = FAULT;
                end else begin
                    nxt_mem_req  = 1'b1;
                    nxt_mem_addr = pc_in;
                end
            end
            HOLD: begin
                if (jump_req) begin
                    next_state    = JUMP;
                    nxt_pc_load   = 1'b1;
                    nxt_pc_preset = jump_addr;
                    nxt_ir_valid  = 1'b0;
                end else if (ir_valid && ir_ready) begin
                    next_state   = REQ;
                    nxt_ir_valid = 1'b0;
                end
            end
            JUMP: begin
                next_state = REQ;
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
